// File: rtl/test_pkg.sv
// ============================================================================
// test_pkg : shared constants and helpers for the toggle / LED chaser block
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package test_pkg;

  localparam int NUM_LEDS = 6;
  localparam int CNT_W    = 4;

  localparam logic [NUM_LEDS-1:0] LED_RESET = 6'b000001;

  // Rotate the one-hot toward the MSB; the top position wraps back to led0.
  function automatic logic [NUM_LEDS-1:0] led_advance(input logic [NUM_LEDS-1:0] cur);
    return {cur[NUM_LEDS-2:0], cur[NUM_LEDS-1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// sync_edge : multi-flop synchronizer plus single-cycle rising-edge detector
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Built only from flop outputs, so it is glitch-free and lasts one cycle.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

`default_nettype wire

// File: rtl/test.sv
// ============================================================================
// test : button-driven toggle, wrapping 4-bit counter and 6-position LED chaser
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module test
  import test_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  output logic o1,
  input  logic in1,
  input  logic clk,
  output logic led0,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic led5,
  input  logic reset
);

  logic                rise;
  logic [CNT_W-1:0]    cnt;
  logic                toggle;
  logic [NUM_LEDS-1:0] led_state;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (in1),
    .rise     (rise)
  );

  // Reset wins over a coincident rise, so that edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      toggle    <= 1'b0;
      led_state <= LED_RESET;
    end else if (rise) begin
      cnt       <= cnt + 1'b1;
      toggle    <= ~toggle;
      led_state <= led_advance(led_state);
    end
  end

  assign o1   = toggle;
  assign led0 = led_state[0];
  assign led1 = led_state[1];
  assign led2 = led_state[2];
  assign led3 = led_state[3];
  assign led4 = led_state[4];
  assign led5 = led_state[5];

endmodule

`default_nettype wire

// File: tb/tb_test.sv
// ============================================================================
// tb_test : directed stimulus with a sample-history model for module test
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_test;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in1 = 1'b0;
  logic o1, led0, led1, led2, led3, led4, led5;

  int checks = 0;
  int failures = 0;

  test #(.SYNC_STAGES(2)) dut (
    .o1    (o1),
    .in1   (in1),
    .clk   (clk),
    .led0  (led0),
    .led1  (led1),
    .led2  (led2),
    .led3  (led3),
    .led4  (led4),
    .led5  (led5),
    .reset (reset)
  );

  always #5 clk = ~clk;

  wire [5:0] leds = {led5, led4, led3, led2, led1, led0};

  // Model: in1 as seen at each edge (forced 0 on reset edges); a rise is
  // a 0->1 step in that history taken two edges back, so outputs move at k+2.
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   m_rises_mod16 = 0;
  int   m_pos = 0;
  logic model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      m_rises_mod16 <= 0;
      m_pos <= 0;
      model_valid <= 1'b1;
    end else begin
      if (s2 && !s3) begin
        m_rises_mod16 <= (m_rises_mod16 + 1) % 16;
        m_pos <= (m_pos + 1) % 6;
      end
      s1 <= in1; s2 <= s1; s3 <= s2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_o1", {31'd0, o1}, m_rises_mod16 % 2);
      check("model_leds", {26'd0, leds}, 32'd1 << m_pos);
      check("model_cnt", {28'd0, dut.cnt}, m_rises_mod16);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in1 = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse();
    in1 = 1'b1;
    tick(2);
    in1 = 1'b0;
    tick(2);
  endtask

  initial begin
    tick(1);
    do_reset();
    check("reset_o1", {31'd0, o1}, 32'd0);
    check("reset_leds", {26'd0, leds}, 32'h01);
    check("reset_cnt", {28'd0, dut.cnt}, 32'd0);

    // Quiet input
    tick(10);
    check("idle_leds", {26'd0, leds}, 32'h01);
    check("idle_o1", {31'd0, o1}, 32'd0);

    // Single 4-cycle pulse: sampled at next edge, outputs two edges after that
    in1 = 1'b1;
    tick(1);
    check("lat_e1_o1", {31'd0, o1}, 32'd0);
    tick(1);
    check("lat_e2_o1", {31'd0, o1}, 32'd0);
    tick(1);
    check("lat_e3_o1", {31'd0, o1}, 32'd1);
    check("lat_e3_leds", {26'd0, leds}, 32'h02);
    tick(1);
    in1 = 1'b0;
    tick(5);
    check("hold_leds", {26'd0, leds}, 32'h02);
    check("hold_o1", {31'd0, o1}, 32'd1);

    // Six rises: full lap back to led0
    do_reset();
    repeat (6) pulse();
    tick(2);
    check("lap_leds", {26'd0, leds}, 32'h01);
    check("lap_o1", {31'd0, o1}, 32'd0);
    check("lap_cnt", {28'd0, dut.cnt}, 32'd6);

    // Seventeen rises: counter wraps, LED at position 5
    do_reset();
    repeat (17) pulse();
    tick(2);
    check("wrap_cnt", {28'd0, dut.cnt}, 32'd1);
    check("wrap_o1", {31'd0, o1}, 32'd1);
    check("wrap_leds", {26'd0, leds}, 32'h20);

    // in1 inverted on every clk transition
    do_reset();
    for (int i = 0; i < 64; i++) begin
      #5 in1 = ~in1;
    end
    in1 = 1'b0;
    tick(4);

    // Reset collides with a pending rise at position 3
    do_reset();
    repeat (3) pulse();
    check("pre_rst_leds", {26'd0, leds}, 32'h08);
    in1 = 1'b1;
    tick(2);
    check("pending_rise", {31'd0, dut.rise}, 32'd1);
    reset = 1'b1;
    tick(1);
    check("rst_pend_leds", {26'd0, leds}, 32'h01);
    check("rst_pend_o1", {31'd0, o1}, 32'd0);
    check("rst_pend_cnt", {28'd0, dut.cnt}, 32'd0);
    reset = 1'b0;
    tick(2);
    check("post_rst_wait", {26'd0, leds}, 32'h01);
    tick(1);
    check("post_rst_leds", {26'd0, leds}, 32'h02);
    check("post_rst_o1", {31'd0, o1}, 32'd1);
    in1 = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/test.md
TEST -- requirements
Module: test

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of input synchronizer flops; legal range is 2..3.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous and active-high: sampled on the rising clk edge, and asserted means reset.
REQ-004 in1  input  1  SHALL be an asynchronous level input, e.g. a button or switch.
REQ-005 o1  output  1  SHALL carry the registered toggle state, inverting once per detected in1 rising edge.
REQ-006 led0..led5  output  1 each  SHALL form a registered one-hot position indicator, with led0 as position 0.
REQ-007 Positional port order SHALL be o1, in1, clk, led0, led1, led2, led3, led4, led5, reset, with reset last.

Function
REQ-008 in1 SHALL pass through SYNC_STAGES flops, followed by one history flop.
REQ-009 rise SHALL be high when the last sync stage is 1 and the history flop is 0.
REQ-010 rise SHALL be high for exactly one clk cycle per synchronized 0->1 transition.
REQ-011 Falling edges and steady levels SHALL have no effect.
REQ-012 Latency: an in1 rising transition sampled at edge k SHALL update the outputs at edge k+SYNC_STAGES (edge k+2 at the default).
REQ-013 An internal 4-bit counter cnt SHALL increment by 1 on each rise.
REQ-014 cnt SHALL wrap from 15 to 0 and SHALL NOT be a port.
REQ-015 o1 SHALL invert on each rise, so o1 equals cnt[0].
REQ-016 The LED one-hot SHALL advance led0->led1->...->led5 on each rise.
REQ-017 From led5 the LED one-hot SHALL wrap to led0.
REQ-018 Exactly one LED SHALL be high at every clock edge after reset.
REQ-019 Without rise, o1, cnt and the LEDs SHALL hold their values.
REQ-020 in1 toggling faster than the synchronizer SHALL still yield at most one rise per two clk cycles, and no output SHALL glitch.
REQ-021 Outputs SHALL be driven directly from flops, with no combinational path from in1 to any output.

Reset
REQ-022 While reset=1 at a clk edge, all synchronizer and history flops SHALL load 0.
REQ-023 While reset=1 at a clk edge, cnt SHALL load 0, o1 SHALL load 0, led0 SHALL load 1 and led1..led5 SHALL load 0.
REQ-024 Reset SHALL take priority over a simultaneous rise; that edge SHALL be discarded.
REQ-025 If in1 is already high when reset deasserts, the first synchronized 1 SHALL count as one rise.
REQ-026 Reset asserted mid-operation SHALL restore the REQ-022/REQ-023 values on the next clk edge, regardless of the current position.

Structure
REQ-027 A shared package SHALL hold NUM_LEDS=6, CNT_W=4 and the LED reset pattern 6'b000001.
REQ-028 The synchronizer plus edge detector SHALL be one sub-module, sync_edge.
REQ-029 sync_edge SHALL take ports clk, reset, async_in and rise, and parameter SYNC_STAGES.
REQ-030 The counter, toggle and LED chaser SHALL reside in test.

Verification
REQ-031 Reset, then hold in1=0 for 10 cycles -> o1=0, led0=1, led1..5=0 throughout.
REQ-032 Apply one in1 0->1 pulse of 4 cycles -> exactly 2 edges later, o1=1 and led1=1 only; no further change while in1 stays high.
REQ-033 Apply 6 clean rising edges -> LEDs step through led1..led5 and then back to led0, and o1 ends at 0.
REQ-034 Apply 17 rising edges -> cnt wraps (15->0->1), o1=1 and led5=1 (17 mod 6 = 5).
REQ-035 Toggle in1 together with clk as a half-period square wave (in1 inverted on each clk toggle, 64 iterations) -> one-hot LEDs and o1=cnt[0] are maintained at every edge, and no X on any output once reset has been applied.
REQ-036 Assert reset while led3=1 and a rise is pending in the same cycle -> next edge gives led0=1, o1=0, cnt=0, and the pending edge is lost.
